// File: rtl/flipflop_arbiter_if.sv
// flipflop_arbiter_if
//   Bundle of signals between the requester blocks and the shared-register
//   arbiter.
//
//   Optional feature macro: FLIPFLOP_ARB_LOCK_EN
//     When defined, the bundle also carries the per-requester lock signal.
//
//   Signals:
//     req   [NREQ]          write request per requester (held until its ack)
//     d     [NREQ*WIDTH]    data words; requester i drives d[i*WIDTH +: WIDTH]
//     lock  [NREQ]          keep-grant request (only with FLIPFLOP_ARB_LOCK_EN)
//     gnt   [NREQ]          one-hot grant, zero when idle
//     ack   [NREQ]          one-cycle write-done pulse to the owner
//     q     [WIDTH]         shared register contents
//     owner [$clog2(NREQ)]  index of the current or last owner
//     busy                  high while the arbiter is not idle
//
//   Modports:
//     master  requester side (drives req/d/lock)
//     slave   arbiter side (drives gnt/ack/q/owner/busy)
interface flipflop_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] d;
`ifdef FLIPFLOP_ARB_LOCK_EN
  logic [NREQ-1:0]       lock;
`endif
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic [OW-1:0]         owner;
  logic                  busy;

`ifdef FLIPFLOP_ARB_LOCK_EN
  modport master (output req, d, lock, input gnt, ack, q, owner, busy);
  modport slave  (input req, d, lock, output gnt, ack, q, owner, busy);
`else
  modport master (output req, d, input gnt, ack, q, owner, busy);
  modport slave  (input req, d, output gnt, ack, q, owner, busy);
`endif
endinterface

// File: rtl/flipflop_arbiter.sv
// flipflop_arbiter
//   Round-robin arbiter that shares one WIDTH-bit register (q) among NREQ
//   requesters. It grants one requester at a time, loads that requester's
//   data word into q, and pulses ack back to it. Each grant walks
//   IDLE -> GRANT -> WRITE -> RELEASE -> IDLE, one state per clock edge.
//
//   Optional feature macro: FLIPFLOP_ARB_LOCK_EN
//     When defined, an owner that holds lock and req in RELEASE keeps the
//     grant and goes straight back to GRANT. This gives back-to-back writes
//     every 3 cycles, and the round-robin pointer is frozen while locked.
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous reset, active-low
//     bus  flipflop_arbiter_if.slave (req, d, [lock] in; gnt, ack, q,
//          owner, busy out)
module flipflop_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  flipflop_arbiter_if.slave bus
);
  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, RELEASE} state_t;

  state_t           state;
  logic [NREQ-1:0]  gnt_r;
  logic [NREQ-1:0]  ack_r;
  logic [WIDTH-1:0] q_r;
  logic [OW-1:0]    owner_r;
  logic             busy_r;
  logic [OW-1:0]    ptr;
  logic [OW-1:0]    winner;
  logic [NREQ-1:0]  owner_bit;

  // Round-robin scan: the first request found above the last served
  // requester (ptr), wrapping around, wins.
  always_comb begin
    winner = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req[(int'(ptr) + k) % NREQ]) winner = OW'((int'(ptr) + k) % NREQ);
    end
  end

  assign owner_bit = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;

  // Main sequencer. Every output is registered here. An asynchronous reset
  // abandons any write in progress and clears q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt_r   <= '0;
      ack_r   <= '0;
      q_r     <= '0;
      owner_r <= '0;
      busy_r  <= 1'b0;
      ptr     <= OW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            gnt_r   <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
            owner_r <= winner;
            busy_r  <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          // If the owner has withdrawn its request, abandon the grant
          // without writing and leave ptr alone.
          if (bus.req[owner_r]) begin
            state <= WRITE;
          end else begin
            gnt_r  <= '0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        WRITE: begin
          q_r   <= bus.d[int'(owner_r)*WIDTH +: WIDTH];
          ack_r <= owner_bit;
          state <= RELEASE;
        end
        RELEASE: begin
          ack_r <= '0;
`ifdef FLIPFLOP_ARB_LOCK_EN
          if (bus.lock[owner_r] && bus.req[owner_r]) begin
            state <= GRANT;
          end else begin
            gnt_r  <= '0;
            busy_r <= 1'b0;
            ptr    <= owner_r;
            state  <= IDLE;
          end
`else
          gnt_r  <= '0;
          busy_r <= 1'b0;
          ptr    <= owner_r;
          state  <= IDLE;
`endif
        end
        default: begin
          gnt_r  <= '0;
          ack_r  <= '0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.ack   = ack_r;
  assign bus.q     = q_r;
  assign bus.owner = owner_r;
  assign bus.busy  = busy_r;
endmodule

// File: tb/tb_flipflop_arbiter.sv
// tb_flipflop_arbiter
//   Directed testbench for flipflop_arbiter with NREQ=4 and WIDTH=4.
//   Outputs are sampled 1 time unit after each rising edge.
//
//   Optional feature macro: FLIPFLOP_ARB_LOCK_EN
//     When defined, the bench also runs the locked back-to-back write
//     sequence.
module tb_flipflop_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  flipflop_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  flipflop_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then move 1 time unit past it.
  task automatic applyStimulus;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.req = '0;
    bus.d   = '0;
`ifdef FLIPFLOP_ARB_LOCK_EN
    bus.lock = '0;
`endif

    // 1. Reset values, then idle with no requests.
    #12;
    checkOutput("rst_gnt",   32'(bus.gnt),   32'h0);
    checkOutput("rst_ack",   32'(bus.ack),   32'h0);
    checkOutput("rst_q",     32'(bus.q),     32'h0);
    checkOutput("rst_owner", 32'(bus.owner), 32'h0);
    checkOutput("rst_busy",  32'(bus.busy),  32'h0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("idle_gnt",  32'(bus.gnt),  32'h0);
      checkOutput("idle_ack",  32'(bus.ack),  32'h0);
      checkOutput("idle_q",    32'(bus.q),    32'h0);
      checkOutput("idle_busy", 32'(bus.busy), 32'h0);
    end

    // 2. A single write from requester 2 with data A.
    bus.req = 4'b0100;
    bus.d   = 16'h0A00;
    applyStimulus();
    checkOutput("t2_gnt",   32'(bus.gnt),   32'h4);
    checkOutput("t2_owner", 32'(bus.owner), 32'h2);
    checkOutput("t2_busy",  32'(bus.busy),  32'h1);
    checkOutput("t2_ack0",  32'(bus.ack),   32'h0);
    applyStimulus();
    checkOutput("t2_gnt_w", 32'(bus.gnt),   32'h4);
    checkOutput("t2_q_pre", 32'(bus.q),     32'h0);
    applyStimulus();
    checkOutput("t2_ack",   32'(bus.ack),   32'h4);
    checkOutput("t2_q",     32'(bus.q),     32'hA);
    bus.req = 4'b0000;
    applyStimulus();
    checkOutput("t2_gnt_off", 32'(bus.gnt),  32'h0);
    checkOutput("t2_ack_off", 32'(bus.ack),  32'h0);
    checkOutput("t2_busy_off",32'(bus.busy), 32'h0);
    checkOutput("t2_q_hold",  32'(bus.q),    32'hA);

    // 3. All four requesting after a fresh reset: served 0,1,2,3,0.
    rst = 1'b0;
    #2;
    checkOutput("t3_rst_q", 32'(bus.q), 32'h0);
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.d   = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      checkOutput("t3_gnt",   32'(bus.gnt),   32'(1 << (k % 4)));
      checkOutput("t3_owner", 32'(bus.owner), 32'(k % 4));
      applyStimulus();
      checkOutput("t3_ack_w", 32'(bus.ack),   32'h0);
      applyStimulus();
      checkOutput("t3_ack",   32'(bus.ack),   32'(1 << (k % 4)));
      checkOutput("t3_q",     32'(bus.q),     32'((k % 4) + 1));
      checkOutput("t3_gnt_r", 32'(bus.gnt),   32'(1 << (k % 4)));
      if (k == 4) bus.req = 4'b0000;
      applyStimulus();
      checkOutput("t3_gnt_off", 32'(bus.gnt), 32'h0);
      checkOutput("t3_ack_off", 32'(bus.ack), 32'h0);
    end

    // 4. Requester 1 drops its request during GRANT; the pointer must stay
    //    at 0, so requester 1 still wins over 2.
    bus.req = 4'b0010;
    applyStimulus();
    checkOutput("t4_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    applyStimulus();
    checkOutput("t4_gnt_abort",  32'(bus.gnt),  32'h0);
    checkOutput("t4_ack_abort",  32'(bus.ack),  32'h0);
    checkOutput("t4_busy_abort", 32'(bus.busy), 32'h0);
    checkOutput("t4_q_abort",    32'(bus.q),    32'h1);
    applyStimulus();
    checkOutput("t4_ack_idle",   32'(bus.ack),  32'h0);
    checkOutput("t4_q_idle",     32'(bus.q),    32'h1);
    bus.req = 4'b0110;
    applyStimulus();
    checkOutput("t4_regrant", 32'(bus.gnt), 32'h2);
    applyStimulus();
    applyStimulus();
    checkOutput("t4_ack", 32'(bus.ack), 32'h2);
    checkOutput("t4_q",   32'(bus.q),   32'h2);
    bus.req = 4'b0000;
    applyStimulus();
    checkOutput("t4_gnt_off", 32'(bus.gnt), 32'h0);

    // 5. Reset asserted during WRITE: outputs clear at once and no write
    //    completes.
    bus.req = 4'b0001;
    bus.d   = 16'h432F;
    applyStimulus();
    checkOutput("t5_gnt", 32'(bus.gnt), 32'h1);
    applyStimulus();
    rst = 1'b0;
    #1;
    checkOutput("t5_rst_gnt",  32'(bus.gnt),  32'h0);
    checkOutput("t5_rst_ack",  32'(bus.ack),  32'h0);
    checkOutput("t5_rst_q",    32'(bus.q),    32'h0);
    checkOutput("t5_rst_busy", 32'(bus.busy), 32'h0);
    applyStimulus();
    checkOutput("t5_rst_q2",   32'(bus.q),    32'h0);
    rst = 1'b1;
    applyStimulus();
    checkOutput("t5_restart_gnt", 32'(bus.gnt), 32'h1);
    applyStimulus();
    applyStimulus();
    checkOutput("t5_ack", 32'(bus.ack), 32'h1);
    checkOutput("t5_q",   32'(bus.q),   32'hF);
    bus.req = 4'b0000;
    applyStimulus();
    checkOutput("t5_gnt_off", 32'(bus.gnt), 32'h0);

`ifdef FLIPFLOP_ARB_LOCK_EN
    // 6. A locked requester 0 gets three writes 3 cycles apart, then
    //    requester 1 is served.
    rst = 1'b0;
    #2;
    rst = 1'b1;
    bus.lock = 4'b0001;
    bus.req  = 4'b0011;
    bus.d    = 16'h4325;
    applyStimulus();
    checkOutput("t6_gnt", 32'(bus.gnt), 32'h1);
    for (int w = 0; w < 3; w++) begin
      applyStimulus();
      checkOutput("t6_ack_w", 32'(bus.ack), 32'h0);
      applyStimulus();
      checkOutput("t6_ack", 32'(bus.ack), 32'h1);
      checkOutput("t6_q",   32'(bus.q),   32'(5 + w));
      bus.d = 16'h4320 | 16'(6 + w);
      if (w == 2) bus.lock = 4'b0000;
      applyStimulus();
      if (w < 2) begin
        checkOutput("t6_gnt_kept", 32'(bus.gnt),  32'h1);
        checkOutput("t6_ack_off",  32'(bus.ack),  32'h0);
        checkOutput("t6_busy",     32'(bus.busy), 32'h1);
      end else begin
        checkOutput("t6_gnt_rel",  32'(bus.gnt),  32'h0);
      end
    end
    applyStimulus();
    checkOutput("t6_next_gnt",   32'(bus.gnt),   32'h2);
    checkOutput("t6_next_owner", 32'(bus.owner), 32'h1);
    applyStimulus();
    applyStimulus();
    checkOutput("t6_next_ack", 32'(bus.ack), 32'h2);
    checkOutput("t6_next_q",   32'(bus.q),   32'h2);
    bus.req = 4'b0000;
    applyStimulus();
    checkOutput("t6_gnt_off", 32'(bus.gnt), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
